// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
// Rebuilds pixel x/y coordinates from an hsync/vsync/active raster stream,
// measures line and frame geometry against the expected timing, and declares
// lock after LOCK_FRAMES consecutive clean frames.
// Optional feature macro: VGA_TIMING_DECODER_ERRCOUNT_EN. When defined,
// err_count counts LOCKED->SEARCH transitions (saturating at 255); when
// undefined err_count is tied to zero.
module vga_timing_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       pix_clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

    localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
    localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACTIVE_C = 11'(V_ACTIVE);
    localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);
    localparam logic [10:0] CNT_MAX    = 11'h7FF;
    localparam logic [9:0]  COORD_MAX  = 10'h3FF;

    // Input stages: s1 is the registered input, s2 the previous s1 sample
    logic hs1_q, vs1_q, act1_q, hs2_q, vs2_q, act2_q;

    // Measurement state
    logic [10:0] hcnt_q, hcnt_d;       // cycles since last hsync rise, incl. the rise cycle
    logic        h_started_q, h_started_d;
    logic [10:0] aw_q, aw_d;           // active cycles in the current line
    logic [10:0] ln_q, ln_d;           // hsync rises since last vsync rise
    logic [10:0] aln_q, aln_d;         // active falls since last vsync rise
    logic [10:0] ln_inc, aln_inc;

    // FSM state
    state_e      state_q, state_d;
    logic [3:0]  clean_q, clean_d;

    // Registered outputs
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        pv_q, pv_d, fs_q, fs_d, locked_q, locked_d, terr_q, terr_d;

    logic hs_rise, vs_rise, act_rise, act_fall;
    logic h_bad, a_bad, v_bad, mismatch;

    // Edge detection and geometry checks; checks are ignored while searching
    always_comb begin
        hs_rise  = hs1_q & ~hs2_q;
        vs_rise  = vs1_q & ~vs2_q;
        act_rise = act1_q & ~act2_q;
        act_fall = act2_q & ~act1_q;

        hcnt_d      = hcnt_q;
        h_started_d = h_started_q;
        h_bad       = 1'b0;
        if (hs_rise) begin
            // The first rise after reset only starts the measurement
            h_bad       = h_started_q && (hcnt_q != H_TOTAL_C);
            hcnt_d      = 11'd1;
            h_started_d = 1'b1;
        end else if (hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + 11'd1;
            // Reaching saturation means the line never ended
            h_bad  = h_started_q && (hcnt_q == CNT_MAX - 11'd1);
        end

        aw_d  = aw_q;
        a_bad = 1'b0;
        if (act_fall) begin
            a_bad = (aw_q != H_ACTIVE_C);
            aw_d  = '0;
        end else if (act1_q && (aw_q != CNT_MAX)) begin
            aw_d = aw_q + 11'd1;
        end

        // A coincident hsync/active edge belongs to the frame being closed
        ln_inc  = (hs_rise && (ln_q != CNT_MAX)) ? ln_q + 11'd1 : ln_q;
        aln_inc = (act_fall && (aln_q != CNT_MAX)) ? aln_q + 11'd1 : aln_q;
        v_bad   = 1'b0;
        if (vs_rise) begin
            v_bad = (ln_inc != V_TOTAL_C) || (aln_inc != V_ACTIVE_C);
            ln_d  = '0;
            aln_d = '0;
        end else begin
            ln_d  = ln_inc;
            aln_d = aln_inc;
        end

        mismatch = (state_q != SEARCH) && (h_bad || a_bad || v_bad);
    end

    // Lock FSM: count clean frames, drop back to SEARCH on any mismatch
    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = ACQUIRE;
                    clean_d = '0;
                end
            end
            ACQUIRE: begin
                if (mismatch) begin
                    state_d = SEARCH;
                end else if (vs_rise) begin
                    clean_d = clean_q + 4'd1;
                    if (clean_q + 4'd1 == LOCK_C) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Coordinate and status outputs, aligned with pixel_valid
    always_comb begin
        x_d = x_q;
        if (act_rise) begin
            x_d = '0;
        end else if (act1_q && (x_q != COORD_MAX)) begin
            x_d = x_q + 10'd1;
        end

        y_d = y_q;
        if (vs_rise) begin
            y_d = '0;
        end else if (act_fall && (y_q != COORD_MAX)) begin
            y_d = y_q + 10'd1;
        end

        pv_d     = act1_q;
        fs_d     = act1_q && (x_d == '0) && (y_d == '0);
        locked_d = (state_d == LOCKED);
        terr_d   = mismatch;
    end

    // State registers with synchronous reset
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            act1_q      <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            act2_q      <= 1'b0;
            hcnt_q      <= '0;
            h_started_q <= 1'b0;
            aw_q        <= '0;
            ln_q        <= '0;
            aln_q       <= '0;
            state_q     <= SEARCH;
            clean_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pv_q        <= 1'b0;
            fs_q        <= 1'b0;
            locked_q    <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            hs1_q       <= hsync_in;
            vs1_q       <= vsync_in;
            act1_q      <= active_in;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            act2_q      <= act1_q;
            hcnt_q      <= hcnt_d;
            h_started_q <= h_started_d;
            aw_q        <= aw_d;
            ln_q        <= ln_d;
            aln_q       <= aln_d;
            state_q     <= state_d;
            clean_q     <= clean_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pv_q        <= pv_d;
            fs_q        <= fs_d;
            locked_q    <= locked_d;
            terr_q      <= terr_d;
        end
    end

`ifdef VGA_TIMING_DECODER_ERRCOUNT_EN
    logic [7:0] errc_q, errc_d;

    // Lock-loss counter, saturating, cleared only by reset
    always_comb begin
        errc_d = errc_q;
        if ((state_q == LOCKED) && (state_d == SEARCH) && (errc_q != 8'hFF)) begin
            errc_d = errc_q + 8'd1;
        end
    end

    // Lock-loss counter register
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            errc_q <= '0;
        end else begin
            errc_q <= errc_d;
        end
    end

    assign err_count = errc_q;
`else
    assign err_count = '0;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_valid = pv_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign timing_err  = terr_q;
endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder using a scaled raster (50x14 total,
// 32x10 active) so that many frames fit in a short run.
module tb_vga_timing_decoder;
    localparam int HT   = 50;
    localparam int VT   = 14;
    localparam int HA   = 32;
    localparam int VA   = 10;
    localparam int LF   = 2;
    localparam int HS_B = HA + 4;
    localparam int HS_E = HA + 10;
    localparam int VS_B = VA + 2;
    localparam int VS_E = VA + 4;
    localparam int M_SEARCH  = 0;
    localparam int M_ACQUIRE = 1;
    localparam int M_LOCKED  = 2;
`ifdef VGA_TIMING_DECODER_ERRCOUNT_EN
    localparam int ERRC_ON = 1;
`else
    localparam int ERRC_ON = 0;
`endif

    logic       pix_clk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in, active_in;
    logic [9:0] x, y;
    logic       pixel_valid, frame_start, locked, timing_err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vga_timing_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .pix_clk(pix_clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .active_in(active_in), .x(x), .y(y), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .err_count(err_count)
    );

    // Clock and cycle counter
    always #5 pix_clk = ~pix_clk;
    always @(posedge pix_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
        end
    endtask

    // Behavioural model: applies the decoder rules to each accepted input
    // sample; results become visible two clock edges after the sample is driven.
    logic [31:0] exp_q[$];
    logic [31:0] exp_cur = '0;
    bit model_on = 0;
    bit m_phs, m_pvs, m_pact, m_seen;
    int m_since, m_aw, m_lines, m_alines, m_mx, m_my, m_state, m_clean, m_errc;

    always @(posedge pix_clk) begin
        bit bad, hr, vr, ar, af;
        int old_state;
        logic [31:0] t;
        if (reset) begin
            m_phs = 0; m_pvs = 0; m_pact = 0; m_seen = 0;
            m_since = 0; m_aw = 0; m_lines = 0; m_alines = 0;
            m_mx = 0; m_my = 0; m_state = M_SEARCH; m_clean = 0; m_errc = 0;
            exp_q.delete();
            exp_cur = '0;
            exp_q.push_back(32'd0);
            model_on = 1;
        end else if (model_on) begin
            hr = hsync_in && !m_phs;
            vr = vsync_in && !m_pvs;
            ar = active_in && !m_pact;
            af = m_pact && !active_in;
            bad = 0;
            if (hr) begin
                if (m_seen && m_since != HT) bad = 1;
                m_since = 1;
                m_seen = 1;
            end else begin
                m_since++;
                if (m_seen && m_since == 2047) bad = 1;
            end
            if (af) begin
                if (m_aw != HA) bad = 1;
                m_aw = 0;
            end else if (active_in) begin
                m_aw++;
            end
            if (hr) m_lines++;
            if (af) m_alines++;
            if (vr) begin
                if (m_lines != VT || m_alines != VA) bad = 1;
                m_lines = 0;
                m_alines = 0;
            end
            if (m_state == M_SEARCH) bad = 0;
            old_state = m_state;
            if (m_state == M_SEARCH) begin
                if (vr) begin m_state = M_ACQUIRE; m_clean = 0; end
            end else if (bad) begin
                m_state = M_SEARCH;
            end else if (vr && m_state == M_ACQUIRE) begin
                m_clean++;
                if (m_clean == LF) m_state = M_LOCKED;
            end
`ifdef VGA_TIMING_DECODER_ERRCOUNT_EN
            if (old_state == M_LOCKED && m_state == M_SEARCH && m_errc < 255) m_errc++;
`endif
            if (ar) m_mx = 0;
            else if (active_in && m_mx < 1023) m_mx++;
            if (vr) m_my = 0;
            else if (af && m_my < 1023) m_my++;
            t = {active_in, 10'(m_mx), 10'(m_my), active_in && m_mx == 0 && m_my == 0,
                 m_state == M_LOCKED, bad, 8'(m_errc)};
            exp_cur = exp_q.pop_front();
            exp_q.push_back(t);
            m_phs = hsync_in;
            m_pvs = vsync_in;
            m_pact = active_in;
        end
    end

    // Event bookkeeping shared by driver and compare process
    int terr_n = 0, fs_n = 0, lock_rise_cyc = -1, last_err_cyc = -1;
    int probe_cyc = -100, rst_cyc = -100, last_hs_cyc = -1, vs3_cyc = -1, vs_rise_n = 0;
    bit prev_locked = 0, probe_en = 0, last_hs = 0, last_vs = 0;

    // Compare process: DUT against model every cycle, plus pinned literals
    always @(negedge pix_clk) begin
        if (model_on) begin
            chk("pixel_valid", pixel_valid, exp_cur[31]);
            if (exp_cur[31]) begin
                chk("x", x, exp_cur[30:21]);
                chk("y", y, exp_cur[20:11]);
            end
            chk("frame_start", frame_start, exp_cur[10]);
            chk("locked", locked, exp_cur[9]);
            chk("timing_err", timing_err, exp_cur[8]);
            chk("err_count", err_count, exp_cur[7:0]);
            if (frame_start === 1'b1) chk("frame_start_xy", {x, y}, 20'd0);
            if (cyc == probe_cyc + 2) begin
                chk("probe_x", x, HA - 1);
                chk("probe_y", y, VA - 1);
                chk("probe_valid", pixel_valid, 1);
            end
            if (cyc == rst_cyc + 1) begin
                chk("rst_outputs", {x, y, pixel_valid, frame_start, locked, timing_err, err_count}, 0);
            end
            if (timing_err === 1'b1) begin
                terr_n++;
                last_err_cyc = cyc;
            end
            if (frame_start === 1'b1) fs_n++;
            if (locked === 1'b1 && !prev_locked && lock_rise_cyc < 0) lock_rise_cyc = cyc;
            prev_locked = (locked === 1'b1);
        end
    end

    // Driver tasks
    task automatic drive_cycle(input logic hs, input logic vs, input logic act, input logic rst);
        hsync_in = hs;
        vsync_in = vs;
        active_in = act;
        reset = rst;
        if (hs && !last_hs) last_hs_cyc = cyc;
        if (vs && !last_vs) begin
            vs_rise_n++;
            if (vs_rise_n == 3) vs3_cyc = cyc;
        end
        if (rst) rst_cyc = cyc;
        last_hs = hs;
        last_vs = vs;
        @(posedge pix_clk);
        #1;
    endtask

    task automatic drive_line(input int v, input int len, input int alen, input int rst_h);
        for (int h = 0; h < len; h++) begin
            if (probe_en && v == VA - 1 && h == HA - 1) probe_cyc = cyc;
            drive_cycle(h >= HS_B && h < HS_E, v >= VS_B && v < VS_E,
                        v < VA && h < alen, h == rst_h);
        end
    endtask

    task automatic drive_frame(input int stretch_v, input int short_v, input int rst_v, input int rst_h);
        for (int v = 0; v < VT; v++) begin
            drive_line(v, (v == stretch_v) ? HT + 1 : HT, (v == short_v) ? HA - 1 : HA,
                       (v == rst_v) ? rst_h : -1);
        end
    endtask

    // Directed scenarios
    initial begin
        int e0, f0;
        reset = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        active_in = 1'b0;
        repeat (3) @(posedge pix_clk);
        #1;
        chk("reset_locked", locked, 0);
        chk("reset_valid", pixel_valid, 0);
        reset = 1'b0;

        // Clean stream: lock at the third vsync rise
        drive_frame(-1, -1, -1, -1);
        drive_frame(-1, -1, -1, -1);
        chk("unlocked_after_2", locked, 0);
        drive_frame(-1, -1, -1, -1);
        chk("locked_after_3", locked, 1);
        chk("lock_cycle", lock_rise_cyc, vs3_cyc + 2);
        chk("no_err_clean", terr_n, 0);

        // Locked frame: last pixel probe and one frame_start
        f0 = fs_n;
        probe_en = 1;
        drive_frame(-1, -1, -1, -1);
        probe_en = 0;
        chk("fs_once", fs_n - f0, 1);

        // Stretched line
        e0 = terr_n;
        drive_frame(3, -1, -1, -1);
        chk("stretch_err_once", terr_n - e0, 1);
        chk("stretch_unlocked", locked, 0);
        drive_frame(-1, -1, -1, -1);
        chk("stretch_relock_1", locked, 0);
        drive_frame(-1, -1, -1, -1);
        chk("stretch_relock_2", locked, 1);
        chk("stretch_errc", err_count, ERRC_ON);

        // Short active line
        e0 = terr_n;
        drive_frame(-1, 5, -1, -1);
        chk("short_err_once", terr_n - e0, 1);
        chk("short_unlocked", locked, 0);
        drive_frame(-1, -1, -1, -1);
        chk("short_relock_1", locked, 0);
        drive_frame(-1, -1, -1, -1);
        chk("short_relock_2", locked, 1);
        chk("short_errc", err_count, 2 * ERRC_ON);

        // One-cycle reset mid-frame
        e0 = terr_n;
        drive_frame(-1, -1, 4, 10);
        chk("rst_unlocked", locked, 0);
        drive_frame(-1, -1, -1, -1);
        chk("rst_relock_1", locked, 0);
        drive_frame(-1, -1, -1, -1);
        chk("rst_relock_2", locked, 1);
        chk("rst_no_err", terr_n - e0, 0);
        chk("rst_errc", err_count, 0);

        // Syncs held low: line counter saturation
        e0 = terr_n;
        for (int i = 0; i < 3000; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_err_once", terr_n - e0, 1);
        chk("sat_err_cycle", last_err_cyc, last_hs_cyc + 2048);
        chk("sat_unlocked", locked, 0);
        chk("sat_errc", err_count, ERRC_ON);

        // Overlong active run: x saturates
        for (int i = 0; i < 1030; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("x_saturate", x, 1023);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
